reg_file_sb: RTL

- Parametrised successor to the single-write, dual-read register file for the RV32IM pipeline.
- Generalises data width, register count and number of read ports.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight producers, plus a registered pending count.
- Sits between the decode stage (reads, issue marking) and the writeback stage (write, pending clear).

---
 rtl/reg_file_pkg.sv | 30 +++
 rtl/reg_file_scoreboard.sv | 65 ++++++
 rtl/reg_file_sb.sv | 87 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Brief    : Shared defaults, register index type and popcount for reg_file_sb
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_IDX = '0;

  // The population count covers register files up to 2**8 entries.
  localparam int POP_MAX_ADDR_W = 8;
  localparam int POP_MAX_W      = 2**POP_MAX_ADDR_W;

  function automatic logic [POP_MAX_ADDR_W:0] popcount(input logic [POP_MAX_W-1:0] vec);
    logic [POP_MAX_ADDR_W:0] n;
    n = '0;
    for (int k = 0; k < POP_MAX_W; k++) begin
      n = n + (POP_MAX_ADDR_W+1)'(vec[k]);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard
// Brief    : Per-register pending-write bits, priority update and pending count
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_issue,
  input  logic [ADDR_W-1:0]        i_issue_addr,
  input  logic                     i_flush,
  input  logic                     i_write,
  input  logic [ADDR_W-1:0]        i_write_addr,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [(2**ADDR_W)-1:0]   o_pending,
  output logic [NUM_RD-1:0]        o_busy,
  output logic [ADDR_W:0]          o_pending_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_p_next;
  logic [ADDR_W:0]  r_cnt;

  // A new producer outranks a flush, which outranks the retiring write.
  always_comb begin
    w_p_next = r_pend;
    for (int a = 0; a < DEPTH; a++) begin
      if (i_issue && (i_issue_addr == ADDR_W'(a)) && !((ZERO_REG != 0) && (a == 0))) begin
        w_p_next[a] = 1'b1;
      end else if (i_flush) begin
        w_p_next[a] = 1'b0;
      end else if (i_write && (i_write_addr == ADDR_W'(a))) begin
        w_p_next[a] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_p_next;
      r_cnt  <= (ADDR_W+1)'(popcount(POP_MAX_W'(w_p_next)));
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    assign o_busy[i] = r_pend[i_rd_addr[i*ADDR_W +: ADDR_W]];
  end

  assign o_pending     = r_pend;
  assign o_pending_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Brief    : Parametrised multi-read register file with pending-write scoreboard.
//            Define REG_FILE_WRITE_BYPASS_EN to forward writeback data to reads.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WRITE,
  input  logic [ADDR_W-1:0]        INADDRESS,
  input  logic [DATA_W-1:0]        IN,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     ISSUE,
  input  logic [ADDR_W-1:0]        ISSUE_ADDR,
  input  logic                     FLUSH,
  output logic [ADDR_W:0]          PENDING_CNT
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  w_pending;
  logic [NUM_RD-1:0] w_sb_busy;
  logic              w_unused_pending;
  logic              w_wr_zero;

  assign w_wr_zero = (ZERO_REG != 0) && (INADDRESS == ADDR_W'(ZERO_IDX));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int a = 0; a < DEPTH; a++) begin
        r_regs[a] <= '0;
      end
    end else if (WRITE && !w_wr_zero) begin
      r_regs[INADDRESS] <= IN;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .i_clk         (CLK),
    .i_rst         (RESET),
    .i_issue       (ISSUE),
    .i_issue_addr  (ISSUE_ADDR),
    .i_flush       (FLUSH),
    .i_write       (WRITE),
    .i_write_addr  (INADDRESS),
    .i_rd_addr     (RD_ADDR),
    .o_pending     (w_pending),
    .o_busy        (w_sb_busy),
    .o_pending_cnt (PENDING_CNT)
  );

  assign w_unused_pending = ^w_pending;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic              w_zero;
    assign w_addr = RD_ADDR[i*ADDR_W +: ADDR_W];
    assign w_zero = (ZERO_REG != 0) && (w_addr == ADDR_W'(ZERO_IDX));
`ifdef REG_FILE_WRITE_BYPASS_EN
    logic w_hit;
    assign w_hit = WRITE && (w_addr == INADDRESS) && !w_zero;
    assign RD_DATA[i*DATA_W +: DATA_W] = w_zero ? '0 : (w_hit ? IN : r_regs[w_addr]);
    assign RD_BUSY[i] = w_sb_busy[i] & ~w_hit;
`else
    assign RD_DATA[i*DATA_W +: DATA_W] = w_zero ? '0 : r_regs[w_addr];
    assign RD_BUSY[i] = w_sb_busy[i];
`endif
  end

endmodule
`default_nettype wire
